// File: rtl/wb_merge_buf_pkg.sv
// Shared definitions for the writeback merge buffer.
// Holds the register address/data bus widths, the x0 address constant and a
// small helper that sizes index fields so they stay at least one bit wide.
package wb_merge_buf_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_DATA_BUS = 32;

  // Writes to this register are architecturally discarded.
  localparam logic [REG_ADDR_BUS-1:0] REG_X0 = '0;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_merge_buf_if.sv
// Bus bundle for wb_merge_buf.
// Group input side : in_valid/in_ready handshake plus per-lane in_we, in_waddr,
//                    in_wdata and in_num (program-order index).
// Regfile side     : rf_we, rf_waddr, rf_wdata, WPORTS wide.
// Forwarding side  : q_addr lookup with q_hit/q_data response; empty flag.
// master = producer/consumer around the buffer, slave = the buffer itself.
interface wb_merge_buf_if import wb_merge_buf_pkg::*; #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int AW     = REG_ADDR_BUS,
  parameter int DW     = REG_DATA_BUS
);
  localparam int NW = idx_w(LANES);

  logic                in_valid;
  logic                in_ready;
  logic [LANES-1:0]    in_we;
  logic [LANES*AW-1:0] in_waddr;
  logic [LANES*DW-1:0] in_wdata;
  logic [LANES*NW-1:0] in_num;

  logic [WPORTS-1:0]    rf_we;
  logic [WPORTS*AW-1:0] rf_waddr;
  logic [WPORTS*DW-1:0] rf_wdata;

  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic          empty;

  modport master (
    output in_valid, in_we, in_waddr, in_wdata, in_num, q_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, empty
  );

  modport slave (
    input  in_valid, in_we, in_waddr, in_wdata, in_num, q_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, empty
  );

endinterface

// File: rtl/wb_merge_buf_resolve.sv
// wb_group_resolve: combinational squash and compaction of one issue group.
// Inputs : we/waddr/wdata/num per lane (num = program order, higher = younger).
// Outputs: surv_cnt survivors, packed into slots 0..surv_cnt-1 in ascending
//          program order (slot_vld/slot_addr/slot_data).
// A lane is squashed when it is disabled, targets x0, or a younger enabled
// lane of the same group writes the same register.
module wb_group_resolve import wb_merge_buf_pkg::*; #(
  parameter int  LANES = 2,
  parameter int  AW    = REG_ADDR_BUS,
  parameter int  DW    = REG_DATA_BUS,
  localparam int NW    = idx_w(LANES),
  localparam int CNTW  = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]    we,
  input  logic [LANES*AW-1:0] waddr,
  input  logic [LANES*DW-1:0] wdata,
  input  logic [LANES*NW-1:0] num,
  output logic [CNTW-1:0]     surv_cnt,
  output logic [LANES-1:0]    slot_vld,
  output logic [LANES*AW-1:0] slot_addr,
  output logic [LANES*DW-1:0] slot_data
);

  logic [LANES-1:0] surv;
  int               rank [LANES];
  int               cnt;

  always_comb begin
    surv = '0;
    for (int i = 0; i < LANES; i++) begin
      surv[i] = we[i] && (waddr[i*AW +: AW] != AW'(REG_X0));
      for (int j = 0; j < LANES; j++) begin
        if (j != i && we[j] &&
            waddr[j*AW +: AW] == waddr[i*AW +: AW] &&
            num[j*NW +: NW] > num[i*NW +: NW])
          surv[i] = 1'b0;
      end
    end
  end

  // Slot of a survivor = number of older survivors; num is unique so ranks
  // of survivors are dense and distinct.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rank[i] = 0;
      for (int j = 0; j < LANES; j++) begin
        if (surv[j] && num[j*NW +: NW] < num[i*NW +: NW])
          rank[i] = rank[i] + 1;
      end
    end
  end

  always_comb begin
    slot_vld  = '0;
    slot_addr = '0;
    slot_data = '0;
    cnt       = 0;
    for (int i = 0; i < LANES; i++) begin
      if (surv[i]) begin
        cnt = cnt + 1;
        slot_vld[rank[i]]             = 1'b1;
        slot_addr[rank[i]*AW +: AW]   = waddr[i*AW +: AW];
        slot_data[rank[i]*DW +: DW]   = wdata[i*DW +: DW];
      end
    end
    surv_cnt = CNTW'(cnt);
  end

endmodule

// File: rtl/wb_merge_buf.sv
// wb_merge_buf: writeback merge buffer between execute and the regfile.
// Ports: clk, rst (synchronous, active-low) and bus (wb_merge_buf_if.slave):
//   in_*  : one issue group per in_valid & in_ready handshake
//   rf_*  : WPORTS regfile write ports, drained from the FIFO head every cycle
//   q_*   : youngest-match forwarding lookup over all pending entries
//   empty : FIFO holds no entries
// The interface instance must use the same LANES/WPORTS/AW/DW as this module.
module wb_merge_buf import wb_merge_buf_pkg::*; #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4,
  parameter int AW     = REG_ADDR_BUS,
  parameter int DW     = REG_DATA_BUS
) (
  input logic          clk,
  input logic          rst,
  wb_merge_buf_if.slave bus
);

  localparam int PW   = idx_w(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CNTW = $clog2(LANES + 1);

  logic [CW-1:0]    count;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];

  logic                in_ready;
  logic                accept;
  logic [CNTW-1:0]     surv_cnt;
  logic [LANES-1:0]    slot_vld;
  logic [LANES*AW-1:0] slot_addr;
  logic [LANES*DW-1:0] slot_data;
  logic [PW-1:0]       eidx [LANES];

  logic [WPORTS-1:0]    pres;
  logic [PW-1:0]        pidx [WPORTS];
  int                   npop;
  logic [WPORTS-1:0]    rf_we;
  logic [WPORTS*AW-1:0] rf_waddr;
  logic [WPORTS*DW-1:0] rf_wdata;
  logic [WPORTS-1:0]    rf_x0;

  logic          q_hit;
  logic [DW-1:0] q_data;

  // Pointer arithmetic modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % DEPTH);
  endfunction

  wb_group_resolve #(
    .LANES (LANES),
    .AW    (AW),
    .DW    (DW)
  ) u_resolve (
    .we        (bus.in_we),
    .waddr     (bus.in_waddr),
    .wdata     (bus.in_wdata),
    .num       (bus.in_num),
    .surv_cnt  (surv_cnt),
    .slot_vld  (slot_vld),
    .slot_addr (slot_addr),
    .slot_data (slot_data)
  );

  // Readiness depends only on registered occupancy, so in_valid never
  // feeds back into in_ready.
  assign in_ready = (DEPTH - int'(count)) >= LANES;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    for (int s = 0; s < LANES; s++)
      eidx[s] = wrap(int'(tail) + s);
  end

  always_comb begin
    pres = '0;
    npop = 0;
    for (int k = 0; k < WPORTS; k++) begin
      pidx[k] = wrap(int'(head) + k);
      pres[k] = k < int'(count);
      if (pres[k])
        npop = npop + 1;
    end
  end

  // A port whose address is rewritten by a younger port in the same cycle
  // is suppressed; the entry still pops.
  always_comb begin
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    for (int k = 0; k < WPORTS; k++) begin
      rf_waddr[k*AW +: AW] = ent_addr[pidx[k]];
      rf_wdata[k*DW +: DW] = ent_data[pidx[k]];
      rf_we[k]             = pres[k];
      for (int j = k + 1; j < WPORTS; j++) begin
        if (pres[j] && ent_addr[pidx[j]] == ent_addr[pidx[k]])
          rf_we[k] = 1'b0;
      end
    end
  end

  // Scan from head towards tail so the last match is the youngest.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int o = 0; o < DEPTH; o++) begin
      if (o < int'(count) && ent_vld[wrap(int'(head) + o)] &&
          ent_addr[wrap(int'(head) + o)] == bus.q_addr &&
          bus.q_addr != AW'(REG_X0)) begin
        q_hit  = 1'b1;
        q_data = ent_data[wrap(int'(head) + o)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      ent_vld <= '0;
    end else begin
      for (int k = 0; k < WPORTS; k++) begin
        if (pres[k])
          ent_vld[pidx[k]] <= 1'b0;
      end
      // Enqueue slots are free slots, so they never collide with pops.
      if (accept) begin
        for (int s = 0; s < LANES; s++) begin
          if (slot_vld[s])
            ent_vld[eidx[s]] <= 1'b1;
        end
        tail <= wrap(int'(tail) + int'(surv_cnt));
      end
      head  <= wrap(int'(head) + npop);
      count <= CW'(int'(count) + (accept ? int'(surv_cnt) : 0) - npop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int s = 0; s < LANES; s++) begin
        if (slot_vld[s]) begin
          ent_addr[eidx[s]] <= slot_addr[s*AW +: AW];
          ent_data[eidx[s]] <= slot_data[s*DW +: DW];
        end
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.rf_we    = rf_we;
  assign bus.rf_waddr = rf_waddr;
  assign bus.rf_wdata = rf_wdata;
  assign bus.q_hit    = q_hit;
  assign bus.q_data   = q_data;
  assign bus.empty    = (count == '0);

  always_comb begin
    for (int k = 0; k < WPORTS; k++)
      rf_x0[k] = rf_we[k] && (rf_waddr[k*AW +: AW] == AW'(REG_X0));
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    int'(count) <= DEPTH);

  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst)
    rf_x0 == '0);

  a_stall_holds: assert property (@(posedge clk) disable iff (!rst)
    (bus.in_valid && !in_ready) |=> (tail == $past(tail)));

endmodule

// File: tb/tb_wb_merge_buf.sv
// Testbench for wb_merge_buf.
// dut1: LANES=2, WPORTS=1, DEPTH=4 (conflict squash, backpressure, forwarding,
//       reset). dut2: LANES=4, WPORTS=2, DEPTH=8 (same-cycle drain collision;
//       with two lanes and two ports every drained pair comes from one
//       already-squashed group, so a wider group is needed to line up two
//       writes to one register on the ports).
// Expected regfile writes are queued when a group is driven and popped by a
// negedge monitor as the DUTs write.
module tb_wb_merge_buf;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  wr_t sb1 [$];
  wr_t sb2 [$];
  wr_t exp1;
  wr_t exp2;
  wr_t got2;

  wb_merge_buf_if #(.LANES(2), .WPORTS(1), .AW(5), .DW(32)) if1 ();
  wb_merge_buf_if #(.LANES(4), .WPORTS(2), .AW(5), .DW(32)) if2 ();

  wb_merge_buf #(.LANES(2), .WPORTS(1), .DEPTH(4), .AW(5), .DW(32)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  wb_merge_buf #(.LANES(4), .WPORTS(2), .DEPTH(8), .AW(5), .DW(32)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  // Scoreboard monitor: every enabled regfile port must match the oldest
  // outstanding expected write.
  always @(negedge clk) begin
    if (if1.rf_we[0] === 1'b1) begin
      vectors++;
      if (sb1.size() == 0) begin
        miscompares++;
        $display("FAIL sb1_extra: got addr=%0d data=%h, want no write",
                 if1.rf_waddr, if1.rf_wdata);
      end else begin
        exp1 = sb1.pop_front();
        if ({if1.rf_waddr, if1.rf_wdata} !== exp1) begin
          miscompares++;
          $display("FAIL sb1_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   if1.rf_waddr, if1.rf_wdata, exp1.a, exp1.d);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (if2.rf_we[k] === 1'b1) begin
        vectors++;
        got2 = {if2.rf_waddr[k*5 +: 5], if2.rf_wdata[k*32 +: 32]};
        if (sb2.size() == 0) begin
          miscompares++;
          $display("FAIL sb2_extra port%0d: got addr=%0d data=%h, want no write",
                   k, got2.a, got2.d);
        end else begin
          exp2 = sb2.pop_front();
          if (got2 !== exp2) begin
            miscompares++;
            $display("FAIL sb2_write port%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                     k, got2.a, got2.d, exp2.a, exp2.d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic drive1(input logic v, input logic [1:0] we,
                        input logic [4:0] a0, input logic [31:0] d0, input logic n0,
                        input logic [4:0] a1, input logic [31:0] d1, input logic n1);
    if1.in_valid = v;
    if1.in_we    = we;
    if1.in_waddr = {a1, a0};
    if1.in_wdata = {d1, d0};
    if1.in_num   = {n1, n0};
  endtask

  // Reference for a two-lane group: youngest write per address wins, x0 and
  // disabled lanes vanish, survivors retire oldest first.
  task automatic push1(input logic [1:0] we,
                       input logic [4:0] a0, input logic [31:0] d0, input logic n0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic n1);
    logic s0, s1;
    s0 = we[0] && (a0 != 5'd0) && !(we[1] && a1 == a0 && n1 > n0);
    s1 = we[1] && (a1 != 5'd0) && !(we[0] && a0 == a1 && n0 > n1);
    if (n0 < n1) begin
      if (s0) sb1.push_back({a0, d0});
      if (s1) sb1.push_back({a1, d1});
    end else begin
      if (s1) sb1.push_back({a1, d1});
      if (s0) sb1.push_back({a0, d0});
    end
  endtask

  task automatic idle_inputs();
    drive1(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    if2.in_valid = 1'b0;
    if2.in_we    = '0;
    if2.in_waddr = '0;
    if2.in_wdata = '0;
    if2.in_num   = {2'd3, 2'd2, 2'd1, 2'd0};
  endtask

  task automatic wait_empty1(input string tag);
    int t;
    t = 0;
    while (if1.empty !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (if1.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_drain_timeout: empty=%b after %0d cycles, want 1", tag, if1.empty, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    if1.q_addr = 5'd5;
    if2.q_addr = 5'd5;
    repeat (3) @(negedge clk);
    vectors++;
    if ({if1.rf_we, if1.q_hit, if1.empty, if1.in_ready} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reset_dut1: got rf_we,q_hit,empty,in_ready=%b, want 0011",
               {if1.rf_we, if1.q_hit, if1.empty, if1.in_ready});
    end
    vectors++;
    if ({if2.rf_we, if2.q_hit, if2.empty, if2.in_ready} !== 5'b00011) begin
      miscompares++;
      $display("FAIL reset_dut2: got rf_we,q_hit,empty,in_ready=%b, want 00011",
               {if2.rf_we, if2.q_hit, if2.empty, if2.in_ready});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_same_addr();
    // Younger lane1 wins.
    drive1(1'b1, 2'b11, 5'd5, 32'h0000_00AA, 1'b0, 5'd5, 32'h0000_00BB, 1'b1);
    push1(2'b11, 5'd5, 32'h0000_00AA, 1'b0, 5'd5, 32'h0000_00BB, 1'b1);
    #1;
    vectors++;
    if (if1.rf_we !== 1'b0 || if1.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL same_addr_no_comb_path: got rf_we=%b empty=%b, want 0 1",
               if1.rf_we, if1.empty);
    end
    @(negedge clk);
    vectors++;
    if (if1.rf_we !== 1'b1 || if1.rf_waddr !== 5'd5 || if1.rf_wdata !== 32'h0000_00BB) begin
      miscompares++;
      $display("FAIL same_addr_lane1: got we=%b addr=%0d data=%h, want 1 5 000000bb",
               if1.rf_we, if1.rf_waddr, if1.rf_wdata);
    end
    // Swapped order: lane0 is now the younger one.
    drive1(1'b1, 2'b11, 5'd5, 32'h0000_00AA, 1'b1, 5'd5, 32'h0000_00BB, 1'b0);
    push1(2'b11, 5'd5, 32'h0000_00AA, 1'b1, 5'd5, 32'h0000_00BB, 1'b0);
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (if1.rf_we !== 1'b1 || if1.rf_wdata !== 32'h0000_00AA) begin
      miscompares++;
      $display("FAIL same_addr_swapped: got we=%b data=%h, want 1 000000aa",
               if1.rf_we, if1.rf_wdata);
    end
    wait_empty1("same_addr");
  endtask

  task automatic test_x0_disabled();
    drive1(1'b1, 2'b01, 5'd0, 32'h1234_5678, 1'b0, 5'd6, 32'h8765_4321, 1'b1);
    push1(2'b01, 5'd0, 32'h1234_5678, 1'b0, 5'd6, 32'h8765_4321, 1'b1);
    vectors++;
    if (if1.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_ready: got in_ready=%b, want 1", if1.in_ready);
    end
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (if1.empty !== 1'b1 || if1.rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_dropped: got empty=%b rf_we=%b, want 1 0", if1.empty, if1.rf_we);
    end
    @(negedge clk);
    vectors++;
    if (if1.empty !== 1'b1 || if1.rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_still_empty: got empty=%b rf_we=%b, want 1 0", if1.empty, if1.rf_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_rdy;
    want_rdy = 4'b1011;  // index = cycle: ready, ready, full, ready
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (if1.in_ready !== want_rdy[c]) begin
        miscompares++;
        $display("FAIL backpressure_ready c%0d: got in_ready=%b, want %b",
                 c, if1.in_ready, want_rdy[c]);
      end
      case (c)
        0: begin
          drive1(1'b1, 2'b11, 5'd20, 32'hB000_0020, 1'b0, 5'd21, 32'hB000_0021, 1'b1);
          push1(2'b11, 5'd20, 32'hB000_0020, 1'b0, 5'd21, 32'hB000_0021, 1'b1);
        end
        1: begin
          drive1(1'b1, 2'b11, 5'd22, 32'hB000_0022, 1'b0, 5'd23, 32'hB000_0023, 1'b1);
          push1(2'b11, 5'd22, 32'hB000_0022, 1'b0, 5'd23, 32'hB000_0023, 1'b1);
        end
        2: drive1(1'b1, 2'b11, 5'd24, 32'hB000_0024, 1'b0, 5'd25, 32'hB000_0025, 1'b1);
        default: push1(2'b11, 5'd24, 32'hB000_0024, 1'b0, 5'd25, 32'hB000_0025, 1'b1);
      endcase
      @(negedge clk);
    end
    idle_inputs();
    vectors++;
    if (if1.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_refull: got in_ready=%b, want 0", if1.in_ready);
    end
    wait_empty1("backpressure");
  endtask

  task automatic test_forward();
    if1.q_addr = 5'd3;
    // Lane1 is older, so addr 11 sits ahead of addr 3 in the FIFO.
    drive1(1'b1, 2'b11, 5'd3, 32'hF0F0_0001, 1'b1, 5'd11, 32'hF0F0_0011, 1'b0);
    push1(2'b11, 5'd3, 32'hF0F0_0001, 1'b1, 5'd11, 32'hF0F0_0011, 1'b0);
    @(negedge clk);
    vectors++;
    if (if1.q_hit !== 1'b1 || if1.q_data !== 32'hF0F0_0001) begin
      miscompares++;
      $display("FAIL fwd_first: got hit=%b data=%h, want 1 f0f00001", if1.q_hit, if1.q_data);
    end
    drive1(1'b1, 2'b01, 5'd3, 32'hF0F0_0002, 1'b0, 5'd0, 32'h0, 1'b1);
    push1(2'b01, 5'd3, 32'hF0F0_0002, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (if1.q_hit !== 1'b1 || if1.q_data !== 32'hF0F0_0002) begin
      miscompares++;
      $display("FAIL fwd_youngest: got hit=%b data=%h, want 1 f0f00002", if1.q_hit, if1.q_data);
    end
    if1.q_addr = 5'd11;
    #1;
    vectors++;
    if (if1.q_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_drained_miss: got hit=%b, want 0", if1.q_hit);
    end
    if1.q_addr = 5'd0;
    #1;
    vectors++;
    if (if1.q_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_x0: got hit=%b, want 0", if1.q_hit);
    end
    wait_empty1("forward");
  endtask

  task automatic test_drain_collision();
    int t;
    vectors++;
    if (if2.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_ready0: got in_ready=%b, want 1", if2.in_ready);
    end
    // Group 1: addrs 1, 2, 7(C), lane3 disabled -> FIFO [1, 2, 7C].
    if2.in_valid = 1'b1;
    if2.in_we    = 4'b0111;
    if2.in_waddr = {5'd9, 5'd7, 5'd2, 5'd1};
    if2.in_wdata = {32'h0000_0099, 32'h0000_00C0, 32'h0000_0022, 32'h0000_0011};
    if2.in_num   = {2'd3, 2'd2, 2'd1, 2'd0};
    sb2.push_back({5'd1, 32'h0000_0011});
    sb2.push_back({5'd2, 32'h0000_0022});
    // 7C lands on port0 next to 7D on port1 and is suppressed.
    @(negedge clk);
    vectors++;
    if (if2.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_ready1: got in_ready=%b, want 1", if2.in_ready);
    end
    if2.in_we    = 4'b1111;
    if2.in_waddr = {5'd15, 5'd14, 5'd13, 5'd7};
    if2.in_wdata = {32'h0000_0015, 32'h0000_0014, 32'h0000_0013, 32'h0000_00D0};
    sb2.push_back({5'd7,  32'h0000_00D0});
    sb2.push_back({5'd13, 32'h0000_0013});
    sb2.push_back({5'd14, 32'h0000_0014});
    sb2.push_back({5'd15, 32'h0000_0015});
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (if2.rf_we !== 2'b10 || if2.rf_waddr !== {5'd7, 5'd7} ||
        if2.rf_wdata[63:32] !== 32'h0000_00D0) begin
      miscompares++;
      $display("FAIL coll_squash: got we=%b addr=%h data1=%h, want 10 e7 000000d0",
               if2.rf_we, if2.rf_waddr, if2.rf_wdata[63:32]);
    end
    vectors++;
    if (if2.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_full: got in_ready=%b, want 0", if2.in_ready);
    end
    @(negedge clk);
    vectors++;
    if (if2.in_ready !== 1'b1 || if2.rf_we !== 2'b11) begin
      miscompares++;
      $display("FAIL coll_popped2: got in_ready=%b rf_we=%b, want 1 11",
               if2.in_ready, if2.rf_we);
    end
    t = 0;
    while (if2.empty !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (if2.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_drain_timeout: empty=%b, want 1", if2.empty);
    end
  endtask

  task automatic test_reset_midop();
    drive1(1'b1, 2'b11, 5'd16, 32'hA000_0016, 1'b0, 5'd17, 32'hA000_0017, 1'b1);
    push1(2'b11, 5'd16, 32'hA000_0016, 1'b0, 5'd17, 32'hA000_0017, 1'b1);
    @(negedge clk);
    drive1(1'b1, 2'b11, 5'd18, 32'hA000_0018, 1'b0, 5'd19, 32'hA000_0019, 1'b1);
    push1(2'b11, 5'd18, 32'hA000_0018, 1'b0, 5'd19, 32'hA000_0019, 1'b1);
    @(negedge clk);
    // Three entries pending here: 17 on the port, 18 and 19 queued.
    idle_inputs();
    if1.q_addr = 5'd18;
    rst = 1'b0;
    #1;
    vectors++;
    if (if1.q_hit !== 1'b1 || if1.empty !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_pending: got q_hit=%b empty=%b, want 1 0", if1.q_hit, if1.empty);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb1.delete();  // 18 and 19 are discarded by the reset
    vectors++;
    if ({if1.rf_we, if1.q_hit, if1.empty, if1.in_ready} !== 4'b0011) begin
      miscompares++;
      $display("FAIL midop_reset: got rf_we,q_hit,empty,in_ready=%b, want 0011",
               {if1.rf_we, if1.q_hit, if1.empty, if1.in_ready});
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (if1.rf_we !== 1'b0 || if1.empty !== 1'b1) begin
        miscompares++;
        $display("FAIL midop_stale c%0d: got rf_we=%b empty=%b, want 0 1",
                 c, if1.rf_we, if1.empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_addr();
    test_x0_disabled();
    test_back_to_back();
    test_forward();
    test_drain_collision();
    test_reset_midop();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb1.size() != 0 || sb2.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d/%0d pending writes, want 0/0", sb1.size(), sb2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
